// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if: received-byte handshake and status pulses between the UART receiver and its consumer
interface uart_rx_frontend_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  modport master (output rx_data, rx_valid, frame_err, overrun, busy, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, busy, output rx_ready);
endinterface

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with mid-bit sampling, one-entry valid/ready
// holding register, and single-cycle framing-error / overrun pulses.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic               pclk,
  input  logic               Reset,
  input  logic               rx,
  uart_rx_frontend_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;
  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          rx_s, bit_end, stop_end, good, load;
  assign rx_s = sync_q[1];
  always_ff @(posedge pclk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = rx_s ? IDLE : START;
      START:     state_d = (cnt_q == HALF) ? (rx_s ? IDLE : DATA) : START;
      DATA:      state_d = (cnt_q == FULL && idx_q == 3'd7) ? STOP : DATA;
      STOP:      state_d = (cnt_q == FULL) ? (rx_s ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
      default:   state_d = IDLE;
    endcase
  end
  // bit_end marks the mid-bit sampling edge of whichever bit is in flight
  always_comb begin
    sync_d   = {sync_q[0], rx};
    bit_end  = (state_q == START) ? (cnt_q == HALF) :
               (state_q == DATA || state_q == STOP) ? (cnt_q == FULL) : 1'b0;
    cnt_d    = (state_q inside {START, DATA, STOP}) && !bit_end ? cnt_q + 1'b1 : '0;
    idx_d    = (state_q == DATA) ? idx_q + 3'(bit_end) : '0;
    shift_d  = shift_q;
    if (state_q == DATA && bit_end) shift_d[idx_q] = rx_s;
    stop_end = (state_q == STOP) && bit_end;
    good     = stop_end && rx_s;
    load     = good && (!valid_q || bus.rx_ready);
    data_d   = load ? shift_q : data_q;
    valid_d  = load || (valid_q && !bus.rx_ready);
    ferr_d   = stop_end && !rx_s;
    ovr_d    = good && valid_q && !bus.rx_ready;
  end
  always_comb begin
    bus.busy      = state_q != IDLE;
    bus.rx_data   = data_q;
    bus.rx_valid  = valid_q;
    bus.frame_err = ferr_q;
    bus.overrun   = ovr_q;
  end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed, table-driven and randomized checks of uart_rx_frontend
// against a frame-level model of the holding register.
module tb_uart_rx_frontend;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  uart_rx_frontend_if bus();
  uart_rx_frontend #(.CLKS_PER_BIT(N)) dut (.pclk(clk), .Reset(rst_n), .rx(rx), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  int ferr_n = 0, ovr_n = 0, vhigh_n = 0, busy_n = 0, rise_cyc = 0, t0_cyc = 0;
  logic vprev = 1'b0;
  logic [7:0] acc_q[$];
  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) acc_q.push_back(bus.rx_data);
    if (bus.frame_err) ferr_n++;
    if (bus.overrun) ovr_n++;
    if (bus.rx_valid) vhigh_n++;
    if (bus.busy) busy_n++;
    if (bus.rx_valid && !vprev) rise_cyc = cyc;
    vprev = bus.rx_valid;
  end
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask
  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic v);
    rx = v;
    cyc_wait(N);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    t0_cyc = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask
  task automatic drain();
    bus.rx_ready = 1'b1;
    cyc_wait(1);
    bus.rx_ready = 1'b0;
  endtask
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;
  vec_t vecs[6];
  initial begin
    int f0, o0, v0, b0, base;
    logic       m_full;
    logic [7:0] m_slot;
    logic [7:0] m_acc[$];
    int         m_ferr, m_ovr;
    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
    vecs[4] = '{8'h01, 1'b0, 1'b0, 8'h80, 1};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};
    bus.rx_ready = 1'b0;
    cyc_wait(3);
    chk("reset_valid", bus.rx_valid, 0);
    chk("reset_data", bus.rx_data, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_ferr", bus.frame_err, 0);
    chk("reset_ovr", bus.overrun, 0);
    rst_n = 1'b1;
    cyc_wait(3);
    // single byte with latency check
    f0 = ferr_n; o0 = ovr_n;
    send_frame(8'hA5, 1'b1);
    cyc_wait(2);
    chk("single_latency", rise_cyc - t0_cyc, 154);
    chk("single_valid", bus.rx_valid, 1);
    chk("single_data", bus.rx_data, 8'hA5);
    chk("single_busy", bus.busy, 0);
    chk("single_ferr", ferr_n - f0, 0);
    chk("single_ovr", ovr_n - o0, 0);
    drain();
    chk("single_drain", bus.rx_valid, 0);
    // table of frames, each starting from an empty holding register
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_n;
      send_frame(vecs[i].data, vecs[i].stop);
      cyc_wait(3);
      chk($sformatf("vec%0d_valid", i), bus.rx_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_data", i), bus.rx_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_ferr", i), ferr_n - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_busy", i), bus.busy, 0);
      drain();
      chk($sformatf("vec%0d_drain", i), bus.rx_valid, 0);
    end
    // back-to-back with consumer always ready
    base = acc_q.size(); o0 = ovr_n; v0 = vhigh_n;
    bus.rx_ready = 1'b1;
    send_frame(8'h55, 1'b1);
    send_frame(8'h0F, 1'b1);
    cyc_wait(4);
    bus.rx_ready = 1'b0;
    chk("b2b_count", acc_q.size() - base, 2);
    if (acc_q.size() - base == 2) begin
      chk("b2b_first", acc_q[base], 8'h55);
      chk("b2b_second", acc_q[base+1], 8'h0F);
    end
    chk("b2b_valid_cycles", vhigh_n - v0, 2);
    chk("b2b_ovr", ovr_n - o0, 0);
    // overrun
    o0 = ovr_n;
    send_frame(8'h11, 1'b1);
    cyc_wait(4);
    send_frame(8'h22, 1'b1);
    cyc_wait(3);
    chk("ovr_pulse", ovr_n - o0, 1);
    chk("ovr_data", bus.rx_data, 8'h11);
    chk("ovr_valid", bus.rx_valid, 1);
    drain();
    chk("ovr_drain", bus.rx_valid, 0);
    // framing error followed by a 40-bit break
    f0 = ferr_n;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h3C >> i));
    send_bit(1'b0);
    cyc_wait(40 * N);
    chk("break_busy", bus.busy, 1);
    chk("break_ferr", ferr_n - f0, 1);
    chk("break_valid", bus.rx_valid, 0);
    rx = 1'b1;
    cyc_wait(4);
    chk("break_release_busy", bus.busy, 0);
    send_frame(8'h81, 1'b1);
    cyc_wait(2);
    chk("after_break_valid", bus.rx_valid, 1);
    chk("after_break_data", bus.rx_data, 8'h81);
    drain();
    // glitch shorter than half a bit
    b0 = busy_n; f0 = ferr_n; v0 = vhigh_n;
    rx = 1'b0;
    cyc_wait(5);
    rx = 1'b1;
    cyc_wait(20);
    chk("glitch_busy_cycles", busy_n - b0, 8);
    chk("glitch_valid", vhigh_n - v0, 0);
    chk("glitch_ferr", ferr_n - f0, 0);
    // reset during data bit 4 of 0xF0 while a byte is held
    send_frame(8'h99, 1'b1);
    cyc_wait(2);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    cyc_wait(N / 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.rx_valid, 0);
    chk("midrst_data", bus.rx_data, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ferr", bus.frame_err, 0);
    chk("midrst_ovr", bus.overrun, 0);
    cyc_wait(3);
    rst_n = 1'b1;
    cyc_wait(4);
    f0 = ferr_n;
    send_frame(8'h7E, 1'b1);
    cyc_wait(3);
    chk("postrst_valid", bus.rx_valid, 1);
    chk("postrst_data", bus.rx_data, 8'h7E);
    chk("postrst_ferr", ferr_n - f0, 0);
    drain();
    // randomized frames against a frame-level holding-register model
    base = acc_q.size(); f0 = ferr_n; o0 = ovr_n;
    m_full = 1'b0; m_slot = '0; m_ferr = 0; m_ovr = 0;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      logic       ok, r, dr;
      int         g;
      b  = 8'($urandom);
      ok = $urandom_range(0, 4) != 0;
      r  = 1'($urandom);
      dr = 1'($urandom);
      g  = $urandom_range(0, 6) + (ok ? 0 : 3);
      if (dr && g == 0) g = 1;
      if (r && m_full) begin m_acc.push_back(m_slot); m_full = 1'b0; end
      if (!ok) m_ferr++;
      else if (m_full) m_ovr++;
      else if (r) m_acc.push_back(b);
      else begin m_slot = b; m_full = 1'b1; end
      bus.rx_ready = r;
      send_frame(b, ok);
      bus.rx_ready = 1'b0;
      if (dr) begin
        if (m_full) begin m_acc.push_back(m_slot); m_full = 1'b0; end
        drain();
        g--;
      end
      cyc_wait(g);
    end
    cyc_wait(4);
    chk("rand_ferr", ferr_n - f0, m_ferr);
    chk("rand_ovr", ovr_n - o0, m_ovr);
    chk("rand_acc_count", acc_q.size() - base, m_acc.size());
    for (int i = 0; i < m_acc.size() && base + i < acc_q.size(); i++)
      chk($sformatf("rand_acc%0d", i), acc_q[base+i], m_acc[i]);
    chk("rand_valid", bus.rx_valid, m_full);
    if (m_full) chk("rand_data", bus.rx_data, m_slot);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

UART serial receiver feeding the UART slave's rx_fifo on the APB bus. It synchronises the asynchronous `rx` pin and samples it at mid-bit. It deframes 8N1 characters, LSB first, and presents each received byte through a one-entry holding register with a valid/ready handshake. Framing errors and overruns are reported as single-cycle pulses, which the UART slave can latch into its status register.

## Interface
- `CLKS_PER_BIT`, default 10417: pclk cycles per bit (100 MHz / 9600 baud, a 104166 ns bit period). Minimum legal value is 4. The counter width is derived from it.
- `pclk`  in  1  clock. All logic is on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous to pclk, idle high.
- `rx_data`  out  8  received byte. Stable while `rx_valid`=1.
- `rx_valid`  out  1  holding register is full.
- `rx_ready`  in  1  consumer (rx_fifo push side) accepts the byte on a rising edge where `rx_valid`=1 and `rx_ready`=1.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while the holding register was still full.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** two flops on `rx`, both reset to 1. `rx_s` is the second flop's output, and all decisions use `rx_s`.
- **Reset:** while `Reset`=0, all outputs are 0, the FSM is in IDLE, the counter is 0, the shift register is 0, and the synchronizer holds 1.
- **IDLE:** on `rx_s`=0, go to START with cnt=0.
- **START:** cnt increments each cycle.
  - At cnt=CLKS_PER_BIT/2−1 (integer division), check `rx_s`.
  - If 0: go to DATA with cnt=0 and bit index 0.
  - If 1: treat as a glitch and return to IDLE. No flags are raised.
- **DATA:** at cnt=CLKS_PER_BIT−1, shift `rx_s` into bit[index], LSB first, and reset cnt to 0.
  - After index 7, go to STOP.
- **STOP:** at cnt=CLKS_PER_BIT−1, sample `rx_s`.
  - If 1 (good frame): deliver the byte to the holding register (rules below), then go to IDLE.
  - If 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. A break condition therefore yields exactly one `frame_err` and no spurious starts.
- **Holding register:**
  - Good frame, `rx_valid`=0: load `rx_data` and set `rx_valid`.
  - Good frame, `rx_valid`=1 and `rx_ready`=1 on the same edge: the old byte is consumed, the new byte is loaded, `rx_valid` stays 1, and there is no overrun.
  - Good frame, `rx_valid`=1 and `rx_ready`=0: keep the old byte, drop the new byte, and pulse `overrun`.
  - No completion: `rx_valid` clears on a handshake edge. `rx_data` keeps its last value.
- `rx_ready` with `rx_valid`=0 has no effect.
- **Reset asserted mid-frame:** the partial frame is discarded immediately. If `rx` is low when reset is released, the low is treated as a start edge and is subject to the START glitch check.

## Timing
Let t0 be the pclk edge at which the first synchronizer flop captures the falling start edge. With N = CLKS_PER_BIT:
- `rx_s` is low after edge t0+1.
- The FSM enters START at edge t0+2.
- The start check is at edge t0+2+N/2.
- Data bit k is sampled at edge t0+2+N/2+(k+1)·N.
- The stop bit is sampled at edge t0+2+N/2+9N.
- `rx_valid` (or `frame_err`/`overrun`) is high in the cycle following that edge.
- `frame_err` and `overrun` are high for exactly one cycle.
- `busy` rises after edge t0+2 and falls after the stop-sample edge.
- A back-to-back start bit immediately after the stop bit is accepted. Because IDLE is reached on the stop-sample edge, the receiver tolerates up to about N/2 cycles of stop-bit shortening.
- There is no combinational path from `rx_ready` to any output.

## Test plan
All scenarios use CLKS_PER_BIT=16 and a bit period of 160 ns at pclk=10 ns.
- **Single byte:** send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with `rx_ready`=0. Required: `rx_valid` rises t0+154 cycles after the start edge, `rx_data`=0xA5, `busy` is low afterwards, and no flags fire. Then set `rx_ready`=1 for one cycle: `rx_valid`=0.
- **Back-to-back:** send 0x55 then 0x0F with `rx_ready` tied to 1. Required: two single-cycle `rx_valid` windows, carrying 0x55 then 0x0F, and `overrun` never asserts.
- **Overrun:** send 0x11 then 0x22 with `rx_ready`=0. Required: an `overrun` pulse at the second stop sample, and `rx_data` stays 0x11. After a handshake, `rx_valid`=0.
- **Framing error and break:** send 0x3C with the stop bit low, then hold `rx` low for 40 bit times, then release. Required: exactly one `frame_err` pulse, `rx_valid` stays 0, and `busy` stays high until the line returns high. A following 0x81 is received correctly.
- **Glitch:** drive `rx` low for 5 cycles, which is shorter than N/2. Required: the FSM returns to IDLE, with no `rx_valid`, no `frame_err`, and a `busy` pulse of 8 cycles.
- **Reset mid-frame:** assert `Reset`=0 during data bit 4 of 0xF0. Required: all outputs read 0 immediately. After release with `rx` high, a new 0x7E is received correctly.
